instruction_decode: RTL and testbench
=====================================

Name: instruction_decode

Overview:
- ID stage of the 5-stage MIPS pipeline, directly downstream of instruction_fetch. Consumes its instr/pc_out.
- Contains:
  - the IF/ID pipeline register;
  - the 32x32 register file with write-back port;
  - the main control decoder and immediate extension;
  - load-use hazard detection that drives stall_fetch back to fetch;
  - the ID/EX output register.

Parameters:
- DATA_W, 32, datapath and register width.
- NUM_REGS, 32, register-file depth; $0 is hardwired to zero.
- NOP_INSTR, 32'h0000_0000, instruction word injected as a bubble.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- instr_in  in  32  instruction word from fetch.
- pc_in  in  32  address of instr_in (fetch pc_out).
- flush  in  1  branch/jump taken in EX; kill IF/ID and ID/EX contents.
- wb_en  in  1  register-file write enable from WB.
- wb_addr  in  5  write-back register index.
- wb_data  in  32  write-back data.
- stall_fetch  out  1  combinational; holds fetch PC and IF/ID register.
- id_valid  out  1  ID/EX holds a real instruction (0 = bubble).
- ctrl  out  12  control bundle; layout is defined in the package.
- rs_data  out  32  operand A.
- rt_data  out  32  operand B.
- imm_ext  out  32  extended immediate.
- rs, rt, rd  out  5 each  register indices for forwarding and destination.
- shamt  out  5  shift amount.
- funct  out  6  function field.
- pc_plus4  out  32  pc_in+4 of the issued instruction.
- jump_target  out  32  {pc_plus4[31:28], instr[25:0], 2'b00}.
- illegal_instr  out  1  opcode/funct not supported; ctrl forced to zero.

Behaviour:
- Reset, synchronous:
  - IF/ID instr = NOP_INSTR, valid = 0.
  - All ID/EX outputs = 0, id_valid = 0.
  - All 32 registers = 0.
  - stall_fetch = 0.
- IF/ID register:
  - captures instr_in/pc_in each cycle with valid = 1 unless stall_fetch.
  - flush=1 loads NOP_INSTR with valid = 0. Flush overrides stall.
- Register file:
  - write at posedge when wb_en && wb_addr != 0.
  - writes to $0 are ignored; reads of $0 return 0.
  - Write-first bypass: if wb_en and wb_addr equals rs/rt being read this cycle (and is non-zero), wb_data is used.
- ID/EX register: one-cycle latency from IF/ID to outputs. On stall or flush it loads a bubble: ctrl = 0, id_valid = 0, other fields don't-care but zeroed.
- Load-use hazard:
  - stall_fetch = id_valid && ctrl.mem_read && ID/EX.rt != 0 && IF/ID.valid && (ID/EX.rt == IF/ID.rs || (uses_rt && ID/EX.rt == IF/ID.rt)).
  - uses_rt is true for R-type, beq, bne, sw.
  - A stall lasts exactly one cycle: the bubble clears the condition.
  - stall_fetch is forced to 0 when flush=1.
- Supported decode:
  - R-type (op 0x00): add 20, sub 22, and 24, or 25, slt 2A, sll 00, srl 02, jr 08.
  - I/J-type: lw 23, sw 2B, beq 04, bne 05, addi 08, slti 0A, andi 0C, ori 0D, lui 0F, j 02, jal 03.
  - Anything else: illegal_instr = 1, ctrl = 0, id_valid still 1.
- Immediate extension:
  - andi/ori zero-extend.
  - lui gives {imm, 16'h0}.
  - All others sign-extend.
- Arithmetic: pc_plus4 is 32-bit modulo; 0xFFFFFFFC + 4 wraps to 0.
- Reset asserted mid-stall or mid-flush: reset wins, and all state returns to reset values on the next edge.

Decomposition:
- Package mips_pkg holds:
  - opcode and funct localparams;
  - ALU-op encoding (4 bits);
  - the ctrl bundle bit positions: reg_write, mem_read, mem_write, mem_to_reg, alu_src, reg_dst, branch, branch_ne, jump, link, plus the 4-bit alu_op field folded in as alu_op[3:2] with {jr} using a dedicated encoding;
  - the NOP constant.
- One sub-module, register_file (2 read ports, 1 write port, bypass), shared later by tests.

Test Plan:
- Reset: rst=1 for 3 cycles with instr_in=32'h2001_0005 -> all outputs 0, stall_fetch=0, id_valid=0. First release cycle still id_valid=0.
- Bypass: wb_en=1, wb_addr=5, wb_data=32'hDEAD_BEEF in the same cycle IF/ID holds add $3,$5,$0 -> next cycle rs_data=32'hDEADBEEF, rd=3, ctrl.reg_write=1.
- $0 protection: wb_addr=0, wb_data=32'h1234, then decode or $4,$0,$0 -> rs_data=0, rt_data=0.
- Load-use: lw $2,0($1) followed by add $4,$2,$3 -> stall_fetch=1 for exactly one cycle; ID/EX shows bubble (id_valid=0); add issues the next cycle with id_valid=1.
- Flush priority: flush=1 in the stall cycle -> stall_fetch=0. Next cycle id_valid=0 and IF/ID bubble; the following instruction issues normally.
- Immediates and illegal:
  - addi imm 0xFFF0 -> imm_ext=0xFFFFFFF0.
  - ori imm 0xFFF0 -> 0x0000FFF0.
  - lui 0x1234 -> 0x12340000.
  - j at pc 0x0040_0000 with target 0x10 -> jump_target=0x0000_0040.
  - opcode 0x3F -> illegal_instr=1, ctrl=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions: opcodes, funct codes, ALU-op encoding and
// the bit layout of the 12-bit control bundle produced by the ID stage.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // alu_op[3:2] is the class carried in ctrl; jr owns class 2'b11 by itself.
  typedef enum logic [3:0] {
    ALU_ADD   = 4'b0000,
    ALU_SLT   = 4'b0001,
    ALU_SUB   = 4'b0100,
    ALU_AND   = 4'b0101,
    ALU_OR    = 4'b0110,
    ALU_LUI   = 4'b0111,
    ALU_FUNCT = 4'b1000,
    ALU_JR    = 4'b1100
  } alu_op_e;

  localparam int CTRL_W       = 12;
  localparam int C_REG_WRITE  = 0;
  localparam int C_MEM_READ   = 1;
  localparam int C_MEM_WRITE  = 2;
  localparam int C_MEM_TO_REG = 3;
  localparam int C_ALU_SRC    = 4;
  localparam int C_REG_DST    = 5;
  localparam int C_BRANCH     = 6;
  localparam int C_BRANCH_NE  = 7;
  localparam int C_JUMP       = 8;
  localparam int C_LINK       = 9;
  localparam int C_ALU_LO     = 10;
  localparam int C_ALU_HI     = 11;

  localparam logic [31:0] NOP = 32'h0000_0000;

endpackage

// File: rtl/register_file.sv
// 2-read / 1-write register file with $0 hardwired to zero and a write-first
// bypass so a value written back this cycle is visible to this cycle's reads.
module register_file #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_a_i,
  input  logic [AW-1:0]     raddr_b_i,
  output logic [DATA_W-1:0] rdata_a_o,
  output logic [DATA_W-1:0] rdata_b_o
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (we_i && waddr_i != '0) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata_a_o = regs_q[raddr_a_i];
    if (raddr_a_i == '0)                    rdata_a_o = '0;
    else if (we_i && waddr_i == raddr_a_i)  rdata_a_o = wdata_i;
  end

  always_comb begin
    rdata_b_o = regs_q[raddr_b_i];
    if (raddr_b_i == '0)                    rdata_b_o = '0;
    else if (we_i && waddr_i == raddr_b_i)  rdata_b_o = wdata_i;
  end

endmodule

// File: rtl/instruction_decode.sv
// MIPS ID stage: IF/ID register, register file, control decode, immediate
// extension, load-use stall generation and the ID/EX output register.
module instruction_decode
  import mips_pkg::*;
#(
  parameter int          DATA_W    = 32,
  parameter int          NUM_REGS  = 32,
  parameter logic [31:0] NOP_INSTR = NOP
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instr_in,
  input  logic [31:0]       pc_in,
  input  logic              flush,
  input  logic              wb_en,
  input  logic [4:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              stall_fetch,
  output logic              id_valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic [31:0]       imm_ext,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [4:0]        shamt,
  output logic [5:0]        funct,
  output logic [31:0]       pc_plus4,
  output logic [31:0]       jump_target,
  output logic              illegal_instr
);

  function automatic logic [31:0] imm_extend(input logic [5:0] op, input logic [15:0] imm);
    logic signed [15:0] simm;
    simm = imm;
    case (op)
      OP_ANDI, OP_ORI: return {16'h0000, imm};
      OP_LUI:          return {imm, 16'h0000};
      default:         return 32'(simm);
    endcase
  endfunction

  logic [31:0]       ifid_instr_q, ifid_pc_q;
  logic              ifid_valid_q;
  logic [DATA_W-1:0] rf_rs_data, rf_rt_data;
  logic [CTRL_W-1:0] ctrl_d;
  logic              illegal_d, uses_rt_d, load_use;
  logic [31:0]       pc_plus4_d;

  logic              id_valid_q, illegal_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [DATA_W-1:0] rs_data_q, rt_data_q;
  logic [31:0]       imm_q, pc_plus4_q, jump_target_q;
  logic [4:0]        rs_q, rt_q, rd_q, shamt_q;
  logic [5:0]        funct_q;

  wire [5:0] op_w = ifid_instr_q[31:26];
  wire [4:0] rs_w = ifid_instr_q[25:21];
  wire [4:0] rt_w = ifid_instr_q[20:16];
  wire [5:0] fn_w = ifid_instr_q[5:0];

  register_file #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) u_rf (
    .clk       (clk),
    .rst       (rst),
    .we_i      (wb_en),
    .waddr_i   (wb_addr),
    .wdata_i   (wb_data),
    .raddr_a_i (rs_w),
    .raddr_b_i (rt_w),
    .rdata_a_o (rf_rs_data),
    .rdata_b_o (rf_rt_data)
  );

  always_comb begin
    logic [9:0] flags;
    alu_op_e    alu;
    flags     = '0;
    alu       = ALU_ADD;
    illegal_d = 1'b0;
    case (op_w)
      OP_RTYPE: case (fn_w)
        FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_SLL, FN_SRL: begin
          flags[C_REG_WRITE] = 1'b1; flags[C_REG_DST] = 1'b1; alu = ALU_FUNCT;
        end
        FN_JR:   begin flags[C_JUMP] = 1'b1; alu = ALU_JR; end
        default: illegal_d = 1'b1;
      endcase
      OP_LW:   begin
        flags[C_REG_WRITE] = 1'b1; flags[C_MEM_READ] = 1'b1;
        flags[C_MEM_TO_REG] = 1'b1; flags[C_ALU_SRC] = 1'b1;
      end
      OP_SW:   begin flags[C_MEM_WRITE] = 1'b1; flags[C_ALU_SRC] = 1'b1; end
      OP_BEQ:  begin flags[C_BRANCH] = 1'b1; alu = ALU_SUB; end
      OP_BNE:  begin flags[C_BRANCH] = 1'b1; flags[C_BRANCH_NE] = 1'b1; alu = ALU_SUB; end
      OP_ADDI: begin flags[C_REG_WRITE] = 1'b1; flags[C_ALU_SRC] = 1'b1; end
      OP_SLTI: begin flags[C_REG_WRITE] = 1'b1; flags[C_ALU_SRC] = 1'b1; alu = ALU_SLT; end
      OP_ANDI: begin flags[C_REG_WRITE] = 1'b1; flags[C_ALU_SRC] = 1'b1; alu = ALU_AND; end
      OP_ORI:  begin flags[C_REG_WRITE] = 1'b1; flags[C_ALU_SRC] = 1'b1; alu = ALU_OR; end
      OP_LUI:  begin flags[C_REG_WRITE] = 1'b1; flags[C_ALU_SRC] = 1'b1; alu = ALU_LUI; end
      OP_J:    flags[C_JUMP] = 1'b1;
      OP_JAL:  begin flags[C_JUMP] = 1'b1; flags[C_LINK] = 1'b1; flags[C_REG_WRITE] = 1'b1; end
      default: illegal_d = 1'b1;
    endcase
    ctrl_d = illegal_d ? '0 : {alu[3:2], flags};
  end

  assign uses_rt_d  = (op_w == OP_RTYPE) || (op_w == OP_BEQ) || (op_w == OP_BNE) || (op_w == OP_SW);
  assign pc_plus4_d = ifid_pc_q + 32'd4;

  // The load sitting in ID/EX cannot forward in time to the consumer in IF/ID.
  assign load_use = id_valid_q && ctrl_q[C_MEM_READ] && (rt_q != '0) && ifid_valid_q &&
                    ((rt_q == rs_w) || (uses_rt_d && rt_q == rt_w));
  assign stall_fetch = load_use && !flush && !rst;

  // IF/ID boundary
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      ifid_instr_q <= NOP_INSTR;
      ifid_pc_q    <= '0;
      ifid_valid_q <= 1'b0;
    end else if (!stall_fetch) begin
      ifid_instr_q <= instr_in;
      ifid_pc_q    <= pc_in;
      ifid_valid_q <= 1'b1;
    end
  end

  // ID/EX boundary
  always_ff @(posedge clk) begin
    if (rst || flush || stall_fetch || !ifid_valid_q) begin
      id_valid_q    <= 1'b0;
      ctrl_q        <= '0;
      rs_data_q     <= '0;
      rt_data_q     <= '0;
      imm_q         <= '0;
      rs_q          <= '0;
      rt_q          <= '0;
      rd_q          <= '0;
      shamt_q       <= '0;
      funct_q       <= '0;
      pc_plus4_q    <= '0;
      jump_target_q <= '0;
      illegal_q     <= 1'b0;
    end else begin
      id_valid_q    <= 1'b1;
      ctrl_q        <= ctrl_d;
      rs_data_q     <= rf_rs_data;
      rt_data_q     <= rf_rt_data;
      imm_q         <= imm_extend(op_w, ifid_instr_q[15:0]);
      rs_q          <= rs_w;
      rt_q          <= rt_w;
      rd_q          <= ifid_instr_q[15:11];
      shamt_q       <= ifid_instr_q[10:6];
      funct_q       <= fn_w;
      pc_plus4_q    <= pc_plus4_d;
      jump_target_q <= {pc_plus4_d[31:28], ifid_instr_q[25:0], 2'b00};
      illegal_q     <= illegal_d;
    end
  end

  assign id_valid      = id_valid_q;
  assign ctrl          = ctrl_q;
  assign rs_data       = rs_data_q;
  assign rt_data       = rt_data_q;
  assign imm_ext       = imm_q;
  assign rs            = rs_q;
  assign rt            = rt_q;
  assign rd            = rd_q;
  assign shamt         = shamt_q;
  assign funct         = funct_q;
  assign pc_plus4      = pc_plus4_q;
  assign jump_target   = jump_target_q;
  assign illegal_instr = illegal_q;

endmodule

// File: tb/tb_instruction_decode.sv
// Bench for instruction_decode: directed scenarios plus a randomized stream
// compared against a transaction-level model of the ID stage.
module tb_instruction_decode;

  logic        clk = 1'b0;
  logic        rst, flush, wb_en;
  logic [31:0] instr_in, pc_in, wb_data;
  logic [4:0]  wb_addr;
  logic        stall_fetch, id_valid, illegal_instr;
  logic [11:0] ctrl;
  logic [31:0] rs_data, rt_data, imm_ext, pc_plus4, jump_target;
  logic [4:0]  rs, rt, rd, shamt;
  logic [5:0]  funct;

  int vectors = 0;
  int miscompares = 0;

  instruction_decode dut (
    .clk(clk), .rst(rst), .instr_in(instr_in), .pc_in(pc_in), .flush(flush),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .stall_fetch(stall_fetch), .id_valid(id_valid), .ctrl(ctrl),
    .rs_data(rs_data), .rt_data(rt_data), .imm_ext(imm_ext),
    .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
    .pc_plus4(pc_plus4), .jump_target(jump_target), .illegal_instr(illegal_instr)
  );

  always #5 clk = ~clk;

  // Control-bundle bits as seen by EX.
  localparam logic [11:0] RW = 12'h001, MR = 12'h002, MW = 12'h004, M2R = 12'h008;
  localparam logic [11:0] AS = 12'h010, RDS = 12'h020, BR = 12'h040, BN = 12'h080;
  localparam logic [11:0] JP = 12'h100, LK = 12'h200;
  localparam logic [11:0] C_ARITH = 12'h400, C_FN = 12'h800, C_JR = 12'hC00;

  typedef struct packed {
    logic        valid;
    logic [11:0] ctrl;
    logic [31:0] a, b, imm;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  funct;
    logic [31:0] pc4, jt;
    logic        ill;
  } exp_t;

  logic [31:0] mregs [32];

  function automatic logic [31:0] r_ins(input int s, input int t, input int d, input int sh, input logic [5:0] fn);
    return {6'h00, 5'(s), 5'(t), 5'(d), 5'(sh), fn};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input int s, input int t, input logic [15:0] imm);
    return {op, 5'(s), 5'(t), imm};
  endfunction

  // {illegal, ctrl} for an instruction word.
  function automatic logic [12:0] ctrl_of(input logic [31:0] ins);
    case (ins[31:26])
      6'h00: case (ins[5:0])
        6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02: return {1'b0, RW | RDS | C_FN};
        6'h08:   return {1'b0, JP | C_JR};
        default: return {1'b1, 12'h000};
      endcase
      6'h23: return {1'b0, RW | MR | M2R | AS};
      6'h2B: return {1'b0, MW | AS};
      6'h04: return {1'b0, BR | C_ARITH};
      6'h05: return {1'b0, BR | BN | C_ARITH};
      6'h08, 6'h0A: return {1'b0, RW | AS};
      6'h0C, 6'h0D, 6'h0F: return {1'b0, RW | AS | C_ARITH};
      6'h02: return {1'b0, JP};
      6'h03: return {1'b0, JP | LK | RW};
      default: return {1'b1, 12'h000};
    endcase
  endfunction

  function automatic logic [31:0] imm_model(input logic [31:0] ins);
    int v;
    if (ins[31:26] == 6'h0C || ins[31:26] == 6'h0D) return 32'(ins[15:0]);
    if (ins[31:26] == 6'h0F) return 32'(ins[15:0]) * 32'h0001_0000;
    v = int'(ins[15:0]);
    if (v >= 32768) v = v - 65536;
    return 32'(v);
  endfunction

  function automatic logic [31:0] reg_read(input logic [4:0] r);
    if (r == 0) return 32'h0;
    if (wb_en && wb_addr == r) return wb_data;
    return mregs[r];
  endfunction

  function automatic exp_t model_issue(input logic [31:0] ins, input logic [31:0] pc);
    exp_t e;
    logic [12:0] c;
    c = ctrl_of(ins);
    e.valid = 1'b1;   e.ctrl = c[11:0];  e.ill = c[12];
    e.rs = ins[25:21]; e.rt = ins[20:16]; e.rd = ins[15:11];
    e.shamt = ins[10:6]; e.funct = ins[5:0];
    e.a = reg_read(ins[25:21]); e.b = reg_read(ins[20:16]);
    e.imm = imm_model(ins);
    e.pc4 = pc + 32'd4;
    e.jt = {e.pc4[31:28], ins[25:0], 2'b00};
    return e;
  endfunction

  function automatic logic reads_rt(input logic [31:0] ins);
    return ins[31:26] inside {6'h00, 6'h04, 6'h05, 6'h2B};
  endfunction

  function automatic logic [31:0] gen_instr();
    int k;
    logic [5:0] fn;
    k = $urandom_range(0, 22);
    case (k)
      0: fn = 6'h20; 1: fn = 6'h22; 2: fn = 6'h24; 3: fn = 6'h25;
      4: fn = 6'h2A; 5: fn = 6'h00; 6: fn = 6'h02; 7: fn = 6'h08;
      default: fn = 6'h3F;
    endcase
    case (k)
      0, 1, 2, 3, 4, 5, 6, 7, 22:
        return r_ins($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 31), $urandom_range(0, 31), fn);
      8, 19, 20: return i_ins(6'h23, $urandom_range(0, 7), $urandom_range(0, 7), 16'($urandom));
      9:  return i_ins(6'h2B, $urandom_range(0, 7), $urandom_range(0, 7), 16'($urandom));
      10: return i_ins(6'h04, $urandom_range(0, 7), $urandom_range(0, 7), 16'($urandom));
      11: return i_ins(6'h05, $urandom_range(0, 7), $urandom_range(0, 7), 16'($urandom));
      12: return i_ins(6'h08, $urandom_range(0, 7), $urandom_range(0, 7), 16'($urandom));
      13: return i_ins(6'h0A, $urandom_range(0, 7), $urandom_range(0, 7), 16'($urandom));
      14: return i_ins(6'h0C, $urandom_range(0, 7), $urandom_range(0, 7), 16'($urandom));
      15: return i_ins(6'h0D, $urandom_range(0, 7), $urandom_range(0, 7), 16'($urandom));
      16: return i_ins(6'h0F, $urandom_range(0, 7), $urandom_range(0, 7), 16'($urandom));
      17: return {6'h02, 26'($urandom)};
      18: return {6'h03, 26'($urandom)};
      default: return {6'h3F, 26'($urandom)};
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; flush = 1'b0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    instr_in = 32'h0; pc_in = 32'h0;
    repeat (2) step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    instr_in = 32'h2001_0005; pc_in = 32'h0000_1000;
    repeat (3) step();
    vectors++;
    if ({id_valid, ctrl, rs_data, rt_data, imm_ext, pc_plus4, jump_target, illegal_instr, stall_fetch} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs got valid=%b ctrl=%h imm=%h pc4=%h stall=%b required all zero",
               id_valid, ctrl, imm_ext, pc_plus4, stall_fetch);
    end
    rst = 1'b0;
    step();
    vectors++;
    if (id_valid !== 1'b0) begin
      miscompares++; $display("FAIL reset_release got id_valid=%b required 0", id_valid);
    end
    step();
    vectors++;
    if ({id_valid, ctrl, imm_ext, rt, pc_plus4} !== {1'b1, RW | AS, 32'h5, 5'd1, 32'h0000_1004}) begin
      miscompares++;
      $display("FAIL first_issue got valid=%b ctrl=%h imm=%h rt=%0d pc4=%h required 1 011 00000005 1 00001004",
               id_valid, ctrl, imm_ext, rt, pc_plus4);
    end
  endtask

  task automatic test_bypass();
    apply_reset();
    instr_in = r_ins(5, 0, 3, 0, 6'h20);
    step();
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEAD_BEEF; instr_in = 32'h0;
    step();
    vectors++;
    if ({id_valid, rs_data, rd, ctrl[0]} !== {1'b1, 32'hDEAD_BEEF, 5'd3, 1'b1}) begin
      miscompares++;
      $display("FAIL bypass got valid=%b rs_data=%h rd=%0d reg_write=%b required 1 deadbeef 3 1",
               id_valid, rs_data, rd, ctrl[0]);
    end
    wb_en = 1'b0; instr_in = r_ins(5, 5, 6, 0, 6'h20);
    step(); step();
    vectors++;
    if ({rs_data, rt_data} !== {32'hDEAD_BEEF, 32'hDEAD_BEEF}) begin
      miscompares++;
      $display("FAIL regfile_store got rs=%h rt=%h required deadbeef deadbeef", rs_data, rt_data);
    end
  endtask

  task automatic test_zero_reg();
    apply_reset();
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'h1234;
    instr_in = r_ins(0, 0, 4, 0, 6'h25);
    step(); step();
    vectors++;
    if ({rs_data, rt_data, rd, id_valid} !== {32'h0, 32'h0, 5'd4, 1'b1}) begin
      miscompares++;
      $display("FAIL zero_reg got rs=%h rt=%h rd=%0d valid=%b required 0 0 4 1", rs_data, rt_data, rd, id_valid);
    end
    wb_en = 1'b0;
  endtask

  task automatic test_load_use();
    apply_reset();
    instr_in = i_ins(6'h23, 1, 2, 16'h0);
    step();
    instr_in = r_ins(2, 3, 4, 0, 6'h20);
    step();
    instr_in = r_ins(0, 0, 7, 0, 6'h25);
    #1;
    vectors++;
    if ({stall_fetch, id_valid, ctrl[1]} !== 3'b111) begin
      miscompares++;
      $display("FAIL load_use_stall got stall=%b valid=%b mem_read=%b required 1 1 1", stall_fetch, id_valid, ctrl[1]);
    end
    step();
    vectors++;
    if ({stall_fetch, id_valid, ctrl} !== '0) begin
      miscompares++;
      $display("FAIL load_use_bubble got stall=%b valid=%b ctrl=%h required 0 0 000", stall_fetch, id_valid, ctrl);
    end
    step();
    vectors++;
    if ({id_valid, rs, rt, rd} !== {1'b1, 5'd2, 5'd3, 5'd4}) begin
      miscompares++;
      $display("FAIL load_use_issue got valid=%b rs=%0d rt=%0d rd=%0d required 1 2 3 4", id_valid, rs, rt, rd);
    end
    step();
    vectors++;
    if ({id_valid, rd} !== {1'b1, 5'd7}) begin
      miscompares++; $display("FAIL load_use_next got valid=%b rd=%0d required 1 7", id_valid, rd);
    end
  endtask

  task automatic test_flush();
    apply_reset();
    instr_in = i_ins(6'h23, 1, 2, 16'h0);
    step();
    instr_in = r_ins(2, 3, 4, 0, 6'h20);
    step();
    flush = 1'b1;
    #1;
    vectors++;
    if (stall_fetch !== 1'b0) begin
      miscompares++; $display("FAIL flush_stall got stall=%b required 0", stall_fetch);
    end
    step();
    flush = 1'b0;
    instr_in = i_ins(6'h0D, 0, 5, 16'h00FF);
    vectors++;
    if (id_valid !== 1'b0) begin
      miscompares++; $display("FAIL flush_bubble got id_valid=%b required 0", id_valid);
    end
    step();
    vectors++;
    if (id_valid !== 1'b0) begin
      miscompares++; $display("FAIL flush_ifid got id_valid=%b required 0", id_valid);
    end
    step();
    vectors++;
    if ({id_valid, rt, imm_ext} !== {1'b1, 5'd5, 32'h0000_00FF}) begin
      miscompares++;
      $display("FAIL flush_resume got valid=%b rt=%0d imm=%h required 1 5 000000ff", id_valid, rt, imm_ext);
    end
    // reset taken while a load-use stall is pending
    instr_in = i_ins(6'h23, 1, 2, 16'h0);
    step();
    instr_in = r_ins(2, 3, 4, 0, 6'h20);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    vectors++;
    if ({id_valid, stall_fetch, ctrl} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_stall got valid=%b stall=%b ctrl=%h required 0 0 000", id_valid, stall_fetch, ctrl);
    end
    step();
    vectors++;
    if (id_valid !== 1'b0) begin
      miscompares++; $display("FAIL reset_mid_stall_ifid got id_valid=%b required 0", id_valid);
    end
  endtask

  task automatic test_immediates();
    logic [31:0] ins [6];
    logic [31:0] pcs [6];
    logic [31:0] imms [6];
    logic [31:0] pc4, jt;
    logic [12:0] c;
    ins[0] = i_ins(6'h08, 0, 1, 16'hFFF0); pcs[0] = 32'h0000_0100; imms[0] = 32'hFFFF_FFF0;
    ins[1] = i_ins(6'h0D, 0, 1, 16'hFFF0); pcs[1] = 32'h0000_0104; imms[1] = 32'h0000_FFF0;
    ins[2] = i_ins(6'h0F, 0, 1, 16'h1234); pcs[2] = 32'h0000_0108; imms[2] = 32'h1234_0000;
    ins[3] = {6'h02, 26'h10};              pcs[3] = 32'h0040_0000; imms[3] = 32'h0000_0010;
    ins[4] = 32'hFC00_0000;                pcs[4] = 32'h0040_0004; imms[4] = 32'h0000_0000;
    ins[5] = i_ins(6'h08, 0, 1, 16'h0001); pcs[5] = 32'hFFFF_FFFC; imms[5] = 32'h0000_0001;
    apply_reset();
    for (int k = 0; k <= 6; k++) begin
      instr_in = (k < 6) ? ins[k] : 32'h0;
      pc_in    = (k < 6) ? pcs[k] : 32'h0;
      step();
      if (k > 0) begin
        pc4 = pcs[k-1] + 32'd4;
        jt  = {pc4[31:28], ins[k-1][25:0], 2'b00};
        c   = ctrl_of(ins[k-1]);
        vectors++;
        if ({id_valid, imm_ext, pc_plus4, jump_target, illegal_instr, ctrl} !== {1'b1, imms[k-1], pc4, jt, c}) begin
          miscompares++;
          $display("FAIL imm_%0d got v=%b imm=%h pc4=%h jt=%h ill=%b ctrl=%h required 1 %h %h %h %b %h",
                   k - 1, id_valid, imm_ext, pc_plus4, jump_target, illegal_instr, ctrl,
                   imms[k-1], pc4, jt, c[12], c[11:0]);
        end
      end
    end
  endtask

  task automatic test_random();
    exp_t        ex, nex;
    logic        ex_load, nex_load, d_v, s_exp;
    logic [31:0] d_ins, d_pc;
    apply_reset();
    for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
    ex = '0; ex_load = 1'b0; d_v = 1'b0; d_ins = 32'h0; d_pc = 32'h0;
    for (int n = 0; n < 600; n++) begin
      instr_in = gen_instr();
      pc_in    = $urandom & 32'hFFFF_FFFC;
      wb_en    = 1'($urandom_range(0, 1));
      wb_addr  = 5'($urandom_range(0, 7));
      wb_data  = $urandom;
      flush    = ($urandom_range(0, 15) == 0);
      s_exp = !flush && ex.valid && ex_load && ex.rt != 0 && d_v &&
              (ex.rt == d_ins[25:21] || (reads_rt(d_ins) && ex.rt == d_ins[20:16]));
      #1;
      vectors++;
      if (stall_fetch !== s_exp) begin
        miscompares++; $display("FAIL rand_stall[%0d] got %b required %b", n, stall_fetch, s_exp);
      end
      if (flush || s_exp || !d_v) begin
        nex = '0; nex_load = 1'b0;
      end else begin
        nex = model_issue(d_ins, d_pc); nex_load = (d_ins[31:26] == 6'h23);
      end
      if (wb_en && wb_addr != 0) mregs[wb_addr] = wb_data;
      if (flush) d_v = 1'b0;
      else if (!s_exp) begin d_ins = instr_in; d_pc = pc_in; d_v = 1'b1; end
      ex = nex; ex_load = nex_load;
      step();
      vectors++;
      if ({id_valid, ctrl, rs_data, rt_data, imm_ext, rs, rt, rd, shamt, funct, pc_plus4, jump_target, illegal_instr} !== ex) begin
        miscompares++;
        $display("FAIL rand_idex[%0d] got %h required %h", n,
                 {id_valid, ctrl, rs_data, rt_data, imm_ext, rs, rt, rd, shamt, funct, pc_plus4, jump_target, illegal_instr}, ex);
      end
    end
    flush = 1'b0; wb_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_zero_reg();
    test_load_use();
    test_flush();
    test_immediates();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
